// File: rtl/blinky_seq_pkg.sv
// Shared definitions for the blinky LED pattern sequencer: CSR word offsets,
// register bit positions and the sequencer state encoding.
package blinky_seq_pkg;

  // CSR word offsets
  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_STATUS = 3'd1;
  localparam logic [2:0] CSR_PERIOD = 3'd2;
  localparam logic [2:0] CSR_LENGTH = 3'd3;
  localparam logic [2:0] CSR_PIDX   = 3'd4;
  localparam logic [2:0] CSR_PDATA  = 3'd5;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_LOOP_BIT   = 1;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_IDX_LSB  = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/blinky_led_sequencer_if.sv
// Bus bundles for the sequencer: the Avalon-MM CSR slave port driven by the
// CPU, and the Avalon-MM master port that writes the LED PIO data register.

interface blinky_csr_if;
  logic [2:0]  csr_address;
  logic        csr_chipselect;
  logic        csr_write_n;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;

  modport master (
    output csr_address, csr_chipselect, csr_write_n, csr_writedata,
    input  csr_readdata
  );

  modport slave (
    input  csr_address, csr_chipselect, csr_write_n, csr_writedata,
    output csr_readdata
  );
endinterface

interface blinky_pio_if;
  logic [31:0] m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport master (
    output m_address, m_write, m_writedata,
    input  m_waitrequest
  );

  modport slave (
    input  m_address, m_write, m_writedata,
    output m_waitrequest
  );
endinterface

// File: rtl/blinky_seq_step_timer.sv
// Loadable down-counter that paces the sequencer steps. A load sets the count;
// afterwards it counts down to zero and holds. expire_o is high while the count
// equals 1, i.e. on the last cycle of the interval.
module blinky_seq_step_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: load has priority, otherwise decrement until zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/blinky_led_sequencer.sv
// Autonomous LED pattern sequencer. The CPU fills a small pattern table and
// sets a step period over the CSR port; once enabled the block writes each
// table entry in turn to the LED PIO data register over the master port.
module blinky_led_sequencer
  import blinky_seq_pkg::*;
#(
  parameter int          LED_WIDTH      = 17,
  parameter int          DEPTH          = 8,
  parameter int          PERIOD_W       = 26,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(12_500_000),
  parameter logic [31:0] PIO_ADDR       = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  blinky_csr_if.slave  csr,
  blinky_pio_if.master m,
  output logic         busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  // CSR state
  logic                 ctrl_enable_q, ctrl_enable_d;
  logic                 ctrl_loop_q, ctrl_loop_d;
  logic [PERIOD_W-1:0]  period_q;
  logic [31:0]          length_q;
  logic [IDX_W-1:0]     pidx_q;
  logic [LED_WIDTH-1:0] table_q [DEPTH];

  // Sequencer state
  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 restart_q, restart_d;
  logic [LED_WIDTH-1:0] wdata_q, wdata_d;

  // Decoded CSR accesses
  logic csr_wr, ctrl_wr, pdata_wr, start_req;
  assign csr_wr    = csr.csr_chipselect && !csr.csr_write_n;
  assign ctrl_wr   = csr_wr && (csr.csr_address == CSR_CTRL);
  assign pdata_wr  = csr_wr && (csr.csr_address == CSR_PDATA);
  assign start_req = ctrl_wr && csr.csr_writedata[CTRL_ENABLE_BIT];

  // CTRL as it will be after this edge, so a disable acts in the same cycle.
  assign ctrl_enable_d = ctrl_wr ? csr.csr_writedata[CTRL_ENABLE_BIT] : ctrl_enable_q;
  assign ctrl_loop_d   = ctrl_wr ? csr.csr_writedata[CTRL_LOOP_BIT]   : ctrl_loop_q;

  // Effective PERIOD/LENGTH: PERIOD 0 behaves as 1, out-of-range LENGTH as DEPTH.
  logic             period_le1;
  logic [LEN_W-1:0] length_eff;
  logic             last_step;
  assign period_le1 = (period_q <= PERIOD_W'(1));
  assign length_eff = ((length_q == 32'd0) || (length_q > 32'(DEPTH)))
                      ? LEN_W'(DEPTH) : length_q[LEN_W-1:0];
  // >= so that a LENGTH shrunk below the current index still ends/wraps the run.
  assign last_step  = (({1'b0, idx_q} + LEN_W'(1)) >= length_eff);

  // Step timer: loaded with PERIOD-1 at accept so the next write starts exactly
  // PERIOD cycles after the accept. PERIOD<=1 bypasses WAIT entirely.
  logic timer_load, timer_expire;

  blinky_seq_step_timer #(
    .WIDTH(PERIOD_W)
  ) u_step_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (timer_load),
    .value_i  (period_q - PERIOD_W'(1)),
    .expire_o (timer_expire)
  );

  // CSR register file (table excluded).
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_enable_q <= 1'b0;
      ctrl_loop_q   <= 1'b0;
      period_q      <= DEFAULT_PERIOD;
      length_q      <= 32'(DEPTH);
      pidx_q        <= '0;
    end else begin
      ctrl_enable_q <= ctrl_enable_d;
      ctrl_loop_q   <= ctrl_loop_d;
      if (csr_wr) begin
        case (csr.csr_address)
          CSR_PERIOD: period_q <= csr.csr_writedata[PERIOD_W-1:0];
          CSR_LENGTH: length_q <= csr.csr_writedata;
          CSR_PIDX:   pidx_q   <= csr.csr_writedata[IDX_W-1:0];
          CSR_PDATA:  pidx_q   <= pidx_q + IDX_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Pattern table, written only through PDATA.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; software loads it before enabling, and leaving it out keeps it a plain register array.
    if (pdata_wr) begin
      table_q[pidx_q] <= csr.csr_writedata[LED_WIDTH-1:0];
    end
  end

  // Next-state logic: advance through WRITE/WAIT, handle disable and restart.
  always_comb begin
    seq_state_e       step_state;
    logic [IDX_W-1:0] step_idx;
    logic             step_done;
    logic             start_xfer;

    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = done_q;
    restart_d  = restart_q;
    timer_load = 1'b0;
    start_xfer = 1'b0;

    // Outcome of finishing the current step.
    step_state = WRITE;
    step_idx   = idx_q + IDX_W'(1);
    step_done  = done_q;
    if (last_step) begin
      if (ctrl_loop_q) begin
        step_idx = '0;
      end else begin
        step_state = IDLE;
        step_idx   = idx_q;
        step_done  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d    = WRITE;
          idx_d      = '0;
          done_d     = 1'b0;
          restart_d  = 1'b0;
          start_xfer = 1'b1;
        end
      end
      WRITE: begin
        // A re-enable during a transfer is remembered until the accept.
        if (start_req) restart_d = 1'b1;
        if (!m.m_waitrequest) begin
          if (!ctrl_enable_d) begin
            state_d   = IDLE;
            restart_d = 1'b0;
          end else if (restart_d) begin
            idx_d      = '0;
            done_d     = 1'b0;
            restart_d  = 1'b0;
            start_xfer = 1'b1;
          end else if (period_le1) begin
            state_d    = step_state;
            idx_d      = step_idx;
            done_d     = step_done;
            start_xfer = (step_state == WRITE);
          end else begin
            timer_load = 1'b1;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (!ctrl_enable_d) begin
          state_d   = IDLE;
          restart_d = 1'b0;
        end else if (restart_q || start_req) begin
          state_d    = WRITE;
          idx_d      = '0;
          done_d     = 1'b0;
          restart_d  = 1'b0;
          start_xfer = 1'b1;
        end else if (timer_expire) begin
          state_d    = step_state;
          idx_d      = step_idx;
          done_d     = step_done;
          start_xfer = (step_state == WRITE);
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the pattern when a transfer begins so it stays stable under stalls
    // and later PDATA writes only show up on the next visit.
    wdata_d = start_xfer ? table_q[idx_d] : wdata_q;
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      restart_q <= restart_d;
      wdata_q   <= wdata_d;
    end
  end

  // Zero-latency CSR read mux; unused bits and write-only offsets read 0.
  logic [31:0] csr_rdata;
  always_comb begin
    csr_rdata = '0;
    case (csr.csr_address)
      CSR_CTRL: begin
        csr_rdata[CTRL_ENABLE_BIT] = ctrl_enable_q;
        csr_rdata[CTRL_LOOP_BIT]   = ctrl_loop_q;
      end
      CSR_STATUS: begin
        csr_rdata[STATUS_BUSY_BIT]                = busy;
        csr_rdata[STATUS_DONE_BIT]                = done_q;
        csr_rdata[STATUS_IDX_LSB +: IDX_W]        = idx_q;
      end
      CSR_PERIOD: csr_rdata[PERIOD_W-1:0] = period_q;
      CSR_LENGTH: csr_rdata               = length_q;
      CSR_PIDX:   csr_rdata[IDX_W-1:0]    = pidx_q;
      default: ;
    endcase
  end

  assign csr.csr_readdata = csr_rdata;
  assign busy             = (state_q != IDLE);
  assign m.m_address      = PIO_ADDR;
  assign m.m_write        = (state_q == WRITE);
  assign m.m_writedata    = 32'(wdata_q);

endmodule
